// File: rtl/riscvga_pkg.sv
// Shared types for the data-memory controller: access size encoding and FSM states.
package riscvga_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Encoding 3 is not a real size; fold it onto word.
  function automatic size_e norm_size(input logic [1:0] s);
    return (s == 2'd3) ? SZ_WORD : size_e'(s);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Load lane selection and sign/zero extension, purely combinational.
module mem_align
  import riscvga_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[8*off_i +: 8];
    half_sel = off_i[1] ? data_i[31:16] : data_i[15:0];
    data_o   = data_i;
    case (size_e'(size_i))
      SZ_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_HALF: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_ctl.sv
// Load/store unit front end: one outstanding data-memory request, REQ/RESP handshake.
// Define MEM_CTL_MISALIGN_EN to trap misaligned half/word accesses via misalign_o.
module mem_ctl
  import riscvga_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_v_i,
  input  logic              ld_v_i,
  input  logic              st_v_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              dmem_req_v_o,
  output logic              dmem_req_we_o,
  output logic [ADDR_W-1:0] dmem_req_addr_o,
  output logic [DATA_W-1:0] dmem_req_wdata_o,
  output logic [3:0]        dmem_req_be_o,
  input  logic              dmem_req_ready_i,
  input  logic              dmem_resp_v_i,
  input  logic [DATA_W-1:0] dmem_resp_data_i,
`ifdef MEM_CTL_MISALIGN_EN
  output logic              misalign_o,
`endif
  output logic              stall_v_o,
  output logic              ld_data_v_o,
  output logic [DATA_W-1:0] ld_data_o
);

  state_e            state_q;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  size_e size_in;
  logic  op_v;
  logic  mis;
  logic  accept;

  assign size_in = norm_size(size_i);
  assign op_v    = ex_v_i & (ld_v_i | st_v_i);
`ifdef MEM_CTL_MISALIGN_EN
  assign mis = op_v & (((size_in == SZ_HALF) & addr_i[0]) |
                       ((size_in == SZ_WORD) & (addr_i[1:0] != 2'b00)));
  logic misalign_q;
  assign misalign_o = misalign_q;
`else
  assign mis = 1'b0;
`endif
  assign accept = op_v & ~mis;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MEM_CTL_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_CTL_MISALIGN_EN
      misalign_q <= (state_q == ST_IDLE) & mis;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= ~ld_v_i;
            size_q  <= size_in;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            data_q  <= wdata_i;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem_req_ready_i) state_q <= we_q ? ST_IDLE : ST_RESP;
        end
        ST_RESP: begin
          if (dmem_resp_v_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request fields come only from captured registers so they hold while ready is low.
  always_comb begin
    dmem_req_v_o    = (state_q == ST_REQ);
    dmem_req_we_o   = we_q;
    dmem_req_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    case (size_q)
      SZ_BYTE: begin
        dmem_req_be_o    = 4'b0001 << addr_q[1:0];
        dmem_req_wdata_o = {4{data_q[7:0]}};
      end
      SZ_HALF: begin
        dmem_req_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
        dmem_req_wdata_o = {2{data_q[15:0]}};
      end
      default: begin
        dmem_req_be_o    = 4'hF;
        dmem_req_wdata_o = data_q;
      end
    endcase
  end

  assign stall_v_o = rst_n_i &
                     (((state_q == ST_IDLE) & accept) |
                      ((state_q == ST_REQ)  & ~(we_q & dmem_req_ready_i)) |
                      ((state_q == ST_RESP) & ~dmem_resp_v_i));

  assign ld_data_v_o = (state_q == ST_RESP) & dmem_resp_v_i;

  mem_align u_align (
    .data_i     (dmem_resp_data_i),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data_o)
  );

endmodule

// File: tb/tb_mem_ctl.sv
// Directed bench for mem_ctl with a byte-lane model of request encoding and load extension.
module tb_mem_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_v, ld_v, st_v, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        req_v, req_we, ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_v;
  logic [31:0] resp_data;
  logic        stall, ld_v_o;
  logic [31:0] ld_data;
`ifdef MEM_CTL_MISALIGN_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  mem_ctl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .ex_v_i           (ex_v),
    .ld_v_i           (ld_v),
    .st_v_i           (st_v),
    .size_i           (size),
    .unsigned_i       (uns),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .dmem_req_v_o     (req_v),
    .dmem_req_we_o    (req_we),
    .dmem_req_addr_o  (req_addr),
    .dmem_req_wdata_o (req_wdata),
    .dmem_req_be_o    (req_be),
    .dmem_req_ready_i (ready),
    .dmem_resp_v_i    (resp_v),
    .dmem_resp_data_i (resp_data),
`ifdef MEM_CTL_MISALIGN_EN
    .misalign_o       (misalign),
`endif
    .stall_v_o        (stall),
    .ld_data_v_o      (ld_v_o),
    .ld_data_o        (ld_data)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;
  logic        exp_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic int n_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int low_lane(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return int'(a[1:0]);
    if (sz == 2'd1) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be = 4'h0;
    for (int i = 0; i < 4; i++)
      if (i >= low_lane(sz, a) && i < low_lane(sz, a) + n_bytes(sz)) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n_bytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                         input logic [31:0] a, input bit u);
    longint v = 0;
    int n = n_bytes(sz);
    for (int k = 0; k < n; k++) v = v | (longint'(rd[8*(low_lane(sz, a)+k) +: 8]) << (8*k));
    if (!u && v[8*n-1]) v = v - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  // Request fields must match the model on every cycle the request is up.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_v) begin
        chk("req_addr", req_addr, exp_addr);
        chk("req_be", {28'h0, req_be}, {28'h0, exp_be});
        chk("req_we", {31'h0, req_we}, {31'h0, exp_we});
        if (exp_we) chk("req_wdata", req_wdata, exp_wdata);
      end
      if (ld_v_o) chk("ld_data", ld_data, exp_ld);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    addr  = $urandom;
    wdata = $urandom;
    size  = r[1:0];
    uns   = r[2];
  endtask

  // lit: literal load result for loads, literal byte enables for stores.
  task automatic do_op(input bit is_ld, input bit both, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd, input int rdy_wait,
                       input int resp_wait, input logic [31:0] rd, input logic [31:0] lit);
    exp_we    = ~is_ld;
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = m_be(sz, a);
    exp_wdata = m_wdata(sz, wd);
    exp_ld    = m_load(rd, sz, a, u);
    ex_v = 1'b1; ld_v = is_ld; st_v = ~is_ld | both;
    size = sz; uns = u; addr = a; wdata = wd;
    @(negedge clk);
    chk("idle_stall", {31'h0, stall}, 32'h1);
    chk("idle_req_v", {31'h0, req_v}, 32'h0);
    step();
    ex_v = 1'b0; ld_v = 1'b0; st_v = 1'b0;
    scramble();
    for (int i = 0; i < rdy_wait; i++) begin
      ready = 1'b0;
      @(negedge clk);
      chk("wait_req_v", {31'h0, req_v}, 32'h1);
      chk("wait_stall", {31'h0, stall}, 32'h1);
      step();
      scramble();
    end
    ready = 1'b1;
    @(negedge clk);
    chk("hs_req_v", {31'h0, req_v}, 32'h1);
    chk("hs_stall", {31'h0, stall}, {31'h0, is_ld});
    if (!is_ld) chk("st_be_lit", {28'h0, req_be}, lit);
    step();
    ready = 1'b0;
    if (is_ld) begin
      for (int i = 0; i < resp_wait; i++) begin
        resp_data = $urandom;
        @(negedge clk);
        chk("resp_wait_req_v", {31'h0, req_v}, 32'h0);
        chk("resp_wait_ld_v", {31'h0, ld_v_o}, 32'h0);
        chk("resp_wait_stall", {31'h0, stall}, 32'h1);
        step();
      end
      resp_v = 1'b1; resp_data = rd;
      @(negedge clk);
      chk("resp_ld_v", {31'h0, ld_v_o}, 32'h1);
      chk("resp_stall", {31'h0, stall}, 32'h0);
      chk("ld_lit", ld_data, lit);
      step();
      resp_v = 1'b0;
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_req_v"}, {31'h0, req_v}, 32'h0);
    chk({tag, "_ld_v"}, {31'h0, ld_v_o}, 32'h0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; ex_v = 1'b1; ld_v = 1'b1; st_v = 1'b0; size = 2'd2; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; ready = 1'b1; resp_v = 1'b1; resp_data = 32'h0;
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req_v", {31'h0, req_v}, 32'h0);
    chk("rst_ld_v", {31'h0, ld_v_o}, 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    step();
    ex_v = 1'b0; ld_v = 1'b0; ready = 1'b0; resp_v = 1'b0;
    step();
    rst_n = 1'b1;
    idle_chk("post_rst");

    // Back-to-back: each op starts the cycle after the previous one completes.
    do_op(0, 0, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 32'hF);
    do_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 0, 0, 32'h80000000, 32'hFFFFFF80);
    do_op(1, 0, 2'd1, 1, 32'h102, 32'h0, 0, 3, 32'hABCD0000, 32'h0000ABCD);
    do_op(0, 0, 2'd0, 0, 32'h201, 32'h123456A5, 4, 0, 32'h0, 32'h2);
    do_op(0, 0, 2'd1, 0, 32'h202, 32'h0000BEEF, 2, 0, 32'h0, 32'hC);
    do_op(1, 0, 2'd3, 0, 32'h300, 32'h0, 1, 1, 32'h89ABCDEF, 32'h89ABCDEF);
    do_op(1, 1, 2'd1, 0, 32'h300, 32'h0, 0, 0, 32'h00008001, 32'hFFFF8001);
    do_op(1, 0, 2'd0, 1, 32'h102, 32'h0, 0, 2, 32'h00F00000, 32'h000000F0);
    do_op(1, 0, 2'd0, 0, 32'h101, 32'h0, 0, 0, 32'h00007F00, 32'h0000007F);
    idle_chk("idle_a");

    // Reset while waiting for a load response; the late response must be dropped.
    exp_we = 1'b0; exp_addr = 32'h400; exp_be = 4'hF; exp_ld = 32'h0;
    ex_v = 1'b1; ld_v = 1'b1; size = 2'd2; addr = 32'h400;
    step();
    ex_v = 1'b0; ld_v = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    @(negedge clk);
    chk("resp_pre_rst_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_req_v", {31'h0, req_v}, 32'h0);
    step();
    rst_n = 1'b1;
    resp_v = 1'b1; resp_data = 32'h12345678;
    @(negedge clk);
    chk("late_resp_ld_v", {31'h0, ld_v_o}, 32'h0);
    chk("late_resp_stall", {31'h0, stall}, 32'h0);
    chk("late_resp_req_v", {31'h0, req_v}, 32'h0);
    step();
    resp_v = 1'b0;
    do_op(0, 0, 2'd0, 0, 32'h503, 32'h000000C3, 0, 0, 32'h0, 32'h8);

`ifdef MEM_CTL_MISALIGN_EN
    ex_v = 1'b1; ld_v = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h101;
    @(negedge clk);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    chk("mis_req_v", {31'h0, req_v}, 32'h0);
    step();
    ex_v = 1'b0; ld_v = 1'b0;
    @(negedge clk);
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_no_req", {31'h0, req_v}, 32'h0);
    step();
    @(negedge clk);
    chk("mis_pulse_end", {31'h0, misalign}, 32'h0);
    chk("mis_still_no_req", {31'h0, req_v}, 32'h0);
    step();
`else
    // Misaligned half store goes out with the low address bit truncated.
    do_op(0, 0, 2'd1, 0, 32'h101, 32'h0000CAFE, 0, 0, 32'h0, 32'h3);
`endif
    idle_chk("idle_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
